// File: rtl/ir_tx_scheduler_if.sv
// ----------------------------------------------------------------------------
// ir_tx_scheduler_if
// Bundles the requester-side handshake and the ir_transmitter-side signals
// of the scheduler into one interface.
//   req_valid  [NUM_REQ]     requester i has a frame pending
//   req_data   [NUM_REQ*32]  frame word of requester i at [32*i+31:32*i]
//   req_ready  [NUM_REQ]     one-hot accept pulse
//   req_done   [NUM_REQ]     one-hot frame-finished pulse
//   req_error  [NUM_REQ]     one-hot frame-never-started pulse
//   tx_data    [32]          word presented to ir_transmitter
//   tx_start                 single-cycle start pulse to ir_transmitter
//   tx_busy                  busy flag from ir_transmitter
//   sched_busy               scheduler is not idle
// The master modport is the environment (clients plus transmitter), and the
// slave modport is the scheduler itself.
// ----------------------------------------------------------------------------
interface ir_tx_scheduler_if #(
    parameter int NUM_REQ = 4
);
    logic [NUM_REQ-1:0]    req_valid;
    logic [NUM_REQ*32-1:0] req_data;
    logic [NUM_REQ-1:0]    req_ready;
    logic [NUM_REQ-1:0]    req_done;
    logic [NUM_REQ-1:0]    req_error;
    logic [31:0]           tx_data;
    logic                  tx_start;
    logic                  tx_busy;
    logic                  sched_busy;

    modport master (
        output req_valid, req_data, tx_busy,
        input  req_ready, req_done, req_error, tx_data, tx_start, sched_busy
    );

    modport slave (
        input  req_valid, req_data, tx_busy,
        output req_ready, req_done, req_error, tx_data, tx_start, sched_busy
    );
endinterface

// File: rtl/ir_tx_scheduler.sv
// ----------------------------------------------------------------------------
// ir_tx_scheduler
// Shares one ir_transmitter between NUM_REQ requesters. Requests are
// arbitrated round-robin. The winner's word is latched onto tx_data, and
// tx_start is pulsed. The scheduler then follows tx_busy to the end of the
// frame and enforces an inter-frame gap before the next grant.
// Ports:
//   clock    system clock
//   reset_n  synchronous active-low reset
//   bus      ir_tx_scheduler_if.slave (request handshake + transmitter side)
// ----------------------------------------------------------------------------
module ir_tx_scheduler #(
    parameter int NUM_REQ       = 4,
    parameter int GAP_CYCLES    = 1000,
    parameter int START_TIMEOUT = 8
) (
    input  logic                 clock,
    input  logic                 reset_n,
    ir_tx_scheduler_if.slave     bus
);

    localparam int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_MAX = (GAP_CYCLES > START_TIMEOUT) ? GAP_CYCLES : START_TIMEOUT;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        WAIT_BUSY,
        WAIT_DONE,
        GAP
    } state_t;

    state_t             state;
    state_t             state_next;
    logic [IDX_W-1:0]   rr_ptr;
    logic [IDX_W-1:0]   owner;
    logic [31:0]        tx_data_q;
    logic [CNT_W-1:0]   cnt;

    logic               grant_found;
    logic [IDX_W-1:0]   grant_idx;
    logic [IDX_W-1:0]   cand;
    logic [NUM_REQ-1:0] ready_vec;
    logic [NUM_REQ-1:0] done_vec;
    logic [NUM_REQ-1:0] error_vec;
    logic               cnt_clear;
    logic               cnt_inc;

    // Round-robin search starts at rr_ptr and wraps. The first valid
    // requester found wins.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = IDX_W'((int'(rr_ptr) + i) % NUM_REQ);
            if (!grant_found && bus.req_valid[cand]) begin
                grant_found = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    // Next-state and pulse decode. One counter is shared by the start
    // timeout and the gap, because those two phases never overlap.
    always_comb begin
        state_next = state;
        ready_vec  = '0;
        done_vec   = '0;
        error_vec  = '0;
        cnt_clear  = 1'b0;
        cnt_inc    = 1'b0;
        case (state)
            IDLE: begin
                if (grant_found) begin
                    ready_vec[grant_idx] = 1'b1;
                    state_next           = START;
                end
            end
            START: begin
                cnt_clear  = 1'b1;
                state_next = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                if (bus.tx_busy) begin
                    state_next = WAIT_DONE;
                end else if (cnt == CNT_W'(START_TIMEOUT - 1)) begin
                    error_vec[owner] = 1'b1;
                    cnt_clear        = 1'b1;
                    state_next       = GAP;
                end else begin
                    cnt_inc = 1'b1;
                end
            end
            WAIT_DONE: begin
                if (!bus.tx_busy) begin
                    done_vec[owner] = 1'b1;
                    cnt_clear       = 1'b1;
                    state_next      = GAP;
                end
            end
            GAP: begin
                if (cnt == CNT_W'(GAP_CYCLES - 1)) begin
                    state_next = IDLE;
                end else begin
                    cnt_inc = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // State, pointer, owner and data registers. tx_data is loaded only in
    // the IDLE grant cycle, so it stays stable for the whole frame.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state     <= IDLE;
            rr_ptr    <= '0;
            owner     <= '0;
            tx_data_q <= '0;
            cnt       <= '0;
        end else begin
            state <= state_next;
            if (state == IDLE && grant_found) begin
                tx_data_q <= bus.req_data[32*int'(grant_idx) +: 32];
                owner     <= grant_idx;
                rr_ptr    <= (grant_idx == IDX_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
            end
            if (cnt_clear) begin
                cnt <= '0;
            end else if (cnt_inc) begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    // The request-side pulses are gated with reset_n. This stops a held
    // request or a falling tx_busy from producing a pulse during the reset
    // cycle of an aborted frame.
    assign bus.req_ready  = ready_vec & {NUM_REQ{reset_n}};
    assign bus.req_done   = done_vec  & {NUM_REQ{reset_n}};
    assign bus.req_error  = error_vec & {NUM_REQ{reset_n}};
    assign bus.tx_data    = tx_data_q;
    assign bus.tx_start   = (state == START);
    assign bus.sched_busy = (state != IDLE);

endmodule

// File: tb/tb_ir_tx_scheduler.sv
// ----------------------------------------------------------------------------
// tb_ir_tx_scheduler
// Directed, self-checking bench for ir_tx_scheduler (4 requesters, short gap).
// A small transmitter model raises tx_busy one cycle after tx_start and holds
// it for 50 cycles. The model can be disabled to exercise the start timeout.
// ----------------------------------------------------------------------------
module tb_ir_tx_scheduler;

    localparam int NREQ    = 4;
    localparam int GAP     = 16;
    localparam int TIMEOUT = 8;
    localparam int BUSY_LEN = 50;
    // grant -> START -> WAIT_BUSY(busy seen) -> 50 busy cycles -> done -> gap -> grant
    localparam int DONE_LAT = BUSY_LEN + 1;
    localparam int GRANT_INTERVAL = 1 + DONE_LAT + GAP + 1;

    typedef struct {
        logic [3:0]  valid;
        int          exp_idx;
        logic [31:0] exp_data;
    } vec_t;

    logic clock = 1'b0;
    logic reset_n = 1'b0;
    bit   model_en = 1'b1;
    int   busy_cnt = 0;
    int   assertions = 0;
    int   failures = 0;
    int   onehot_viol = 0;
    int   bit3_pulses = 0;
    bit   count_bit3 = 1'b0;
    logic [31:0] lane [4];
    vec_t vecs [8];

    ir_tx_scheduler_if #(.NUM_REQ(NREQ)) bus ();

    ir_tx_scheduler #(
        .NUM_REQ(NREQ),
        .GAP_CYCLES(GAP),
        .START_TIMEOUT(TIMEOUT)
    ) dut (
        .clock(clock),
        .reset_n(reset_n),
        .bus(bus)
    );

    always #5 clock = ~clock;

    // Transmitter model: busy rises on the edge after tx_start and lasts BUSY_LEN cycles.
    always @(posedge clock) begin
        if (!reset_n) begin
            bus.tx_busy <= 1'b0;
            busy_cnt    <= 0;
        end else if (bus.tx_start && model_en) begin
            bus.tx_busy <= 1'b1;
            busy_cnt    <= BUSY_LEN;
        end else if (busy_cnt > 1) begin
            busy_cnt <= busy_cnt - 1;
        end else if (busy_cnt == 1) begin
            busy_cnt    <= 0;
            bus.tx_busy <= 1'b0;
        end
    end

    // Pulse-vector monitor: more than one bit set is a violation, and bit 3 activity is tallied on request.
    always @(negedge clock) begin
        if ($countones(bus.req_ready) > 1 || $countones(bus.req_done) > 1 ||
            $countones(bus.req_error) > 1)
            onehot_viol++;
        if (count_bit3 && (bus.req_ready[3] || bus.req_done[3] || bus.req_error[3]))
            bit3_pulses++;
    end

    initial begin
        #2ms;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        assertions++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [3:0] mask);
        bus.req_valid = mask;
    endtask

    task automatic waitIdle();
        int n = 0;
        while (bus.sched_busy && n < 300) begin
            @(negedge clock);
            n++;
        end
        checkOutput("wait idle", {31'b0, bus.sched_busy}, 32'd0);
    endtask

    // Issue a single request mask, then follow its frame through done and the gap.
    task automatic runFrame(input logic [3:0] mask, input int exp_idx,
                            input logic [31:0] exp_data, input string tag);
        logic [3:0] onehot;
        bit seen;
        bit data_ok;
        int lat;
        int gapc;
        onehot = 4'b0001 << exp_idx;
        @(posedge clock); #1;
        applyStimulus(mask);
        seen = 0;
        for (int c = 0; c < 200 && !seen; c++) begin
            @(negedge clock);
            if (bus.req_ready != 4'b0) seen = 1;
        end
        checkOutput({tag, " ready"}, {28'b0, bus.req_ready}, {28'b0, onehot});
        @(posedge clock); #1;
        applyStimulus(4'b0000);
        @(negedge clock);
        checkOutput({tag, " tx_start"}, {31'b0, bus.tx_start}, 32'd1);
        checkOutput({tag, " tx_data"}, bus.tx_data, exp_data);
        checkOutput({tag, " ready one cycle"}, {28'b0, bus.req_ready}, 32'd0);
        lat = 0;
        seen = 0;
        data_ok = 1;
        while (!seen && lat < 300) begin
            @(negedge clock);
            lat++;
            if (bus.tx_data !== exp_data) data_ok = 0;
            if (bus.req_done != 4'b0) seen = 1;
        end
        checkOutput({tag, " done"}, {28'b0, bus.req_done}, {28'b0, onehot});
        checkOutput({tag, " done latency"}, lat, DONE_LAT);
        checkOutput({tag, " tx_data held"}, {31'b0, data_ok}, 32'd1);
        gapc = 0;
        do begin
            @(negedge clock);
            if (bus.sched_busy) gapc++;
        end while (bus.sched_busy && gapc < 300);
        checkOutput({tag, " gap length"}, gapc, GAP);
    endtask

    task automatic doReset();
        @(posedge clock); #1;
        reset_n = 1'b0;
        applyStimulus(4'b1111);
        @(posedge clock); #1;
        @(negedge clock);
        checkOutput("reset ready", {28'b0, bus.req_ready}, 32'd0);
        checkOutput("reset sched_busy", {31'b0, bus.sched_busy}, 32'd0);
        checkOutput("reset tx_start", {31'b0, bus.tx_start}, 32'd0);
        checkOutput("reset tx_data", bus.tx_data, 32'd0);
        checkOutput("reset done/error", {24'b0, bus.req_done, bus.req_error}, 32'd0);
        @(posedge clock); #1;
        applyStimulus(4'b0000);
        reset_n = 1'b1;
    endtask

    initial begin
        int since;
        int lat;
        bit seen;
        bit done_seen;
        int order [5];
        lane[0] = 32'h0000_C0DE;
        lane[1] = 32'hBEEF_0001;
        lane[2] = 32'hA5A5_5A5A;
        lane[3] = 32'hFFFF_0003;
        bus.req_data  = {lane[3], lane[2], lane[1], lane[0]};
        bus.req_valid = 4'b0000;

        // rr pointer evolves from 0 across these entries (hand-traced)
        vecs[0] = '{4'b0010, 1, 32'hBEEF_0001};
        vecs[1] = '{4'b0011, 0, 32'h0000_C0DE};
        vecs[2] = '{4'b0011, 1, 32'hBEEF_0001};
        vecs[3] = '{4'b1100, 2, 32'hA5A5_5A5A};
        vecs[4] = '{4'b1111, 3, 32'hFFFF_0003};
        vecs[5] = '{4'b1000, 3, 32'hFFFF_0003};
        vecs[6] = '{4'b0101, 0, 32'h0000_C0DE};
        vecs[7] = '{4'b0101, 2, 32'hA5A5_5A5A};

        doReset();
        for (int v = 0; v < 8; v++)
            runFrame(vecs[v].valid, vecs[v].exp_idx, vecs[v].exp_data, $sformatf("vec%0d", v));

        // All four requesters are held continuously after a fresh reset.
        doReset();
        order = '{0, 1, 2, 3, 0};
        @(posedge clock); #1;
        applyStimulus(4'b1111);
        since = 0;
        for (int k = 0; k < 5; k++) begin
            seen = 0;
            for (int c = 0; c < 200 && !seen; c++) begin
                @(negedge clock);
                since++;
                if (bus.req_ready != 4'b0) seen = 1;
            end
            checkOutput($sformatf("rr grant %0d", k), {28'b0, bus.req_ready},
                        32'd1 << order[k]);
            if (k > 0)
                checkOutput($sformatf("rr interval %0d", k), since, GRANT_INTERVAL);
            since = 0;
            @(negedge clock);
            since++;
            checkOutput($sformatf("rr data %0d", k), bus.tx_data, lane[order[k]]);
        end
        @(posedge clock); #1;
        applyStimulus(4'b0000);
        waitIdle();

        // The transmitter never responds, so the frame ends in a start timeout (rr=1, so requester 2 wins).
        model_en = 1'b0;
        @(posedge clock); #1;
        applyStimulus(4'b0100);
        seen = 0;
        for (int c = 0; c < 200 && !seen; c++) begin
            @(negedge clock);
            if (bus.req_ready != 4'b0) seen = 1;
        end
        checkOutput("timeout ready", {28'b0, bus.req_ready}, 32'h4);
        @(posedge clock); #1;
        applyStimulus(4'b0000);
        @(negedge clock);
        checkOutput("timeout tx_start", {31'b0, bus.tx_start}, 32'd1);
        lat = 0;
        seen = 0;
        done_seen = 0;
        while (!seen && lat < 100) begin
            @(negedge clock);
            lat++;
            if (bus.req_done != 4'b0) done_seen = 1;
            if (bus.req_error != 4'b0) seen = 1;
        end
        checkOutput("timeout error", {28'b0, bus.req_error}, 32'h4);
        checkOutput("timeout latency", lat, TIMEOUT);
        for (int c = 0; c < GAP + 4; c++) begin
            @(negedge clock);
            if (bus.req_done != 4'b0) done_seen = 1;
        end
        checkOutput("timeout no done", {31'b0, done_seen}, 32'd0);
        checkOutput("timeout back idle", {31'b0, bus.sched_busy}, 32'd0);
        model_en = 1'b1;

        // Reset is applied mid-frame during WAIT_DONE (rr=3, so requester 0 wins by wrap).
        @(posedge clock); #1;
        applyStimulus(4'b0001);
        seen = 0;
        for (int c = 0; c < 200 && !seen; c++) begin
            @(negedge clock);
            if (bus.req_ready != 4'b0) seen = 1;
        end
        checkOutput("abort ready", {28'b0, bus.req_ready}, 32'h1);
        @(posedge clock); #1;
        applyStimulus(4'b0000);
        repeat (10) @(negedge clock);
        @(posedge clock); #1;
        reset_n = 1'b0;
        @(posedge clock); #1;
        reset_n = 1'b1;
        @(negedge clock);
        checkOutput("abort sched_busy", {31'b0, bus.sched_busy}, 32'd0);
        checkOutput("abort tx_data", bus.tx_data, 32'd0);
        checkOutput("abort pulses", {19'b0, bus.tx_start, bus.req_ready, bus.req_done, bus.req_error}, 32'd0);
        done_seen = 0;
        for (int c = 0; c < 80; c++) begin
            @(negedge clock);
            if (bus.req_done != 4'b0) done_seen = 1;
        end
        checkOutput("abort no done", {31'b0, done_seen}, 32'd0);
        runFrame(4'b0011, 0, lane[0], "post-reset");

        // Requester 3 withdraws while requester 1 is being served (rr=1).
        @(posedge clock); #1;
        applyStimulus(4'b1010);
        seen = 0;
        for (int c = 0; c < 200 && !seen; c++) begin
            @(negedge clock);
            if (bus.req_ready != 4'b0) seen = 1;
        end
        checkOutput("withdraw ready", {28'b0, bus.req_ready}, 32'h2);
        @(posedge clock); #1;
        applyStimulus(4'b0000);
        count_bit3 = 1'b1;
        repeat (120) @(negedge clock);
        count_bit3 = 1'b0;
        checkOutput("withdraw no pulses", bit3_pulses, 32'd0);

        checkOutput("one-hot pulses", onehot_viol, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
        $finish;
    end

endmodule
